// File: rtl/hilo_md_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the legal multiplier pipeline depth.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 4;

  function automatic bit mul_stages_ok(input int n);
    return (n >= MUL_STAGES_MIN) && (n <= MUL_STAGES_MAX);
  endfunction

endpackage

// File: rtl/hilo_md_unit_if.sv
// Issue/result handshake between the execute stage (master) and the
// multiply/divide unit (slave).
interface hilo_md_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             out_valid;
  logic             out_ready;
  logic             commit_en;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready, commit_en,
    input  in_ready, out_valid, out_hi, out_lo
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready, commit_en,
    output in_ready, out_valid, out_hi, out_lo
  );
endinterface

// File: rtl/hilo_md_unit_divider.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Works on magnitudes and fixes signs on the way out. done is combinational
// and coincides with the final iteration so the caller can capture the result
// on that same edge. Optional macro MD_DIV_EARLY_OUT_EN: finish on the cycle
// after start when |dividend| < |divisor|.
module md_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             active, early_q, neg_q, rneg_q, dvz_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, dd_q;
  logic [WIDTH-1:0] dd_mag, dvs_mag, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh;
  logic             ge, early_start;

  assign dd_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

`ifdef MD_DIV_EARLY_OUT_EN
  assign early_start = (divisor != '0) && (dd_mag < dvs_mag);
`else
  assign early_start = 1'b0;
`endif

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};
  assign done   = active && (early_q || (cnt == CNT_W'(1)));

  // Sign fix-up of the final step; divide-by-zero forces an all-ones quotient.
  always_comb begin
    quotient  = neg_q ? -quo_nx : quo_nx;
    remainder = rneg_q ? -rem_nx : rem_nx;
    if (dvz_q) quotient = '1;
    if (early_q) begin
      quotient  = '0;
      remainder = dd_q;
    end
  end

  // Load operands on start, then shift/subtract once per cycle until done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      early_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dvz_q   <= 1'b0;
      cnt     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dd_q    <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      early_q <= early_start;
      neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rneg_q  <= signed_op & dividend[WIDTH-1];
      dvz_q   <= (divisor == '0);
      cnt     <= CNT_W'(WIDTH);
      quo_q   <= dd_mag;
      rem_q   <= '0;
      dvs_q   <= dvs_mag;
      dd_q    <= dividend;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional macro MD_DIV_EARLY_OUT_EN enables the divider's early exit.
//
// state  | meaning
// S_IDLE | ready to accept an op
// S_MUL  | product moving through the multiplier pipeline
// S_DIV  | iterative divide in progress
// S_DONE | result presented, waiting for out_ready
module hilo_md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  hilo_md_unit_if.slave    md,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  if (!mul_stages_ok(MUL_STAGES)) begin : g_bad_mul_stages
    $error("hilo_md_unit: MUL_STAGES must be within 1..4");
  end

  md_state_e          state, state_nx;
  md_op_e             op_q;
  logic [2:0]         mul_cnt;
  logic [2*WIDTH-1:0] mul_pipe [MUL_STAGES];
  logic [2*WIDTH-1:0] res_q, res_out, mul_prod;
  logic               accept, is_mul_in, is_div_in, is_mul_q, mul_signed;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign md.in_ready = (state == S_IDLE) && !flush;
  assign accept      = md.in_valid && md.in_ready;
  assign is_mul_in   = (md.in_op == MD_MULT) || (md.in_op == MD_MULTU);
  assign is_div_in   = (md.in_op == MD_DIV)  || (md.in_op == MD_DIVU);
  assign mul_signed  = (md.in_op == MD_MULT);
  assign is_mul_q    = (op_q == MD_MULT) || (op_q == MD_MULTU);

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves both flavours.
  assign mul_prod = {{WIDTH{mul_signed & md.in_src1[WIDTH-1]}}, md.in_src1} *
                    {{WIDTH{mul_signed & md.in_src2[WIDTH-1]}}, md.in_src2};

  md_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div_in),
    .abort     (flush),
    .signed_op (md.in_op == MD_DIV),
    .dividend  (md.in_src1),
    .divisor   (md.in_src2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush wins over accept and handshake.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (md.in_valid) begin
          if (is_mul_in)      state_nx = (MUL_STAGES == 1) ? S_DONE : S_MUL;
          else if (is_div_in) state_nx = S_DIV;
          else                state_nx = S_DONE;
        end
        S_MUL:  if (mul_cnt == 3'd1) state_nx = S_DONE;
        S_DIV:  if (div_done)        state_nx = S_DONE;
        S_DONE: if (md.out_ready)    state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Op latch, multiplier pipeline and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= MD_NOP;
      mul_cnt <= '0;
      res_q   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else if (accept) begin
      op_q  <= (md.in_op == 3'd7) ? MD_NOP : md_op_e'(md.in_op);
      res_q <= {md.in_src1, md.in_src1};
      if (is_mul_in) begin
        mul_pipe[0] <= mul_prod;
        mul_cnt     <= 3'(MUL_STAGES - 1);
      end
    end else if (state == S_MUL && !flush) begin
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
      mul_cnt <= mul_cnt - 3'd1;
    end else if (state == S_DIV && div_done && !flush) begin
      res_q <= {div_rem, div_quo};
    end
  end

  assign res_out      = is_mul_q ? mul_pipe[MUL_STAGES-1] : res_q;
  assign md.out_hi    = res_out[2*WIDTH-1:WIDTH];
  assign md.out_lo    = res_out[WIDTH-1:0];
  assign md.out_valid = (state == S_DONE);
  assign busy         = (state != S_IDLE);

  // Architectural HI/LO: written only on a committed, unflushed handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_DONE && md.out_ready && md.commit_en && !flush) begin
      case (op_q)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          hi <= md.out_hi;
          lo <= md.out_lo;
        end
        MD_MTHI: hi <= md.out_hi;
        MD_MTLO: lo <= md.out_lo;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
module tb_hilo_md_unit;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clk, reset, flush, busy;
  logic [W-1:0]  hi, lo;
  int            n_tests = 0;
  int            n_fail  = 0;

  hilo_md_unit_if #(.WIDTH(W)) mdi ();

  hilo_md_unit #(.WIDTH(W), .MUL_STAGES(MS), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .md    (mdi.slave),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {latency, hi, lo} computed straight from arithmetic rules.
  function automatic logic [95:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, q, r, ma, mb;
    logic [63:0] p;
    int lat;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    lat = 1;
    case (op)
      3'd1: begin p = 64'(sa * sb); lat = MS; end
      3'd2: begin p = 64'(ua * ub); lat = MS; end
      3'd3, 3'd4: begin
        ma = (op == 3'd3) ? ((sa < 0) ? -sa : sa) : ua;
        mb = (op == 3'd3) ? ((sb < 0) ? -sb : sb) : ub;
        if (b == 0) begin
          q = -1; r = (op == 3'd3) ? sa : ua;
        end else if (op == 3'd3) begin
          q = sa / sb; r = sa % sb;
        end else begin
          q = ua / ub; r = ua % ub;
        end
        p = {r[31:0], q[31:0]};
        lat = W + 1;
`ifdef MD_DIV_EARLY_OUT_EN
        if (b != 0 && ma < mb) lat = 2;
`endif
      end
      3'd5, 3'd6: p = {a, a};
      default: p = '0;
    endcase
    return {32'(lat), p};
  endfunction

  // Behavioural model: one outstanding op with a countdown to its result.
  logic [95:0] cand;
  logic        m_pend, m_valid;
  int          m_left;
  logic [63:0] m_res;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_hi, m_lo;

  assign cand = md_ref(mdi.in_op, mdi.in_src1, mdi.in_src2);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= 0; m_valid <= 0; m_left <= 0; m_res <= '0;
      m_op <= '0; m_a <= '0; m_hi <= '0; m_lo <= '0;
    end else if (flush) begin
      m_pend <= 0; m_valid <= 0;
    end else if (!m_pend && !m_valid) begin
      if (mdi.in_valid) begin
        m_res <= cand[63:0];
        m_op  <= mdi.in_op;
        m_a   <= mdi.in_src1;
        if (cand[95:64] == 1) m_valid <= 1;
        else begin m_pend <= 1; m_left <= int'(cand[95:64]) - 1; end
      end
    end else if (m_pend) begin
      if (m_left == 1) begin m_pend <= 0; m_valid <= 1; end
      m_left <= m_left - 1;
    end else if (mdi.out_ready) begin
      m_valid <= 0;
      if (mdi.commit_en) begin
        case (m_op)
          3'd1, 3'd2, 3'd3, 3'd4: begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
          3'd5: m_hi <= m_a;
          3'd6: m_lo <= m_a;
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("out_valid", mdi.out_valid, m_valid);
      chk("in_ready", mdi.in_ready, !m_pend && !m_valid && !flush);
      chk("busy", busy, m_pend || m_valid);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (m_valid && m_op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
        chk("out_hi", mdi.out_hi, m_res[63:32]);
        chk("out_lo", mdi.out_lo, m_res[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ce);
    int n = 0;
    while (!mdi.in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
    mdi.in_valid = 1; mdi.in_op = op; mdi.in_src1 = a; mdi.in_src2 = b;
    mdi.commit_en = ce; mdi.out_ready = 0;
    tick();
    mdi.in_valid = 0; mdi.in_src1 = $urandom; mdi.in_src2 = $urandom;
    mdi.in_op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!mdi.out_valid && cyc < 100) begin tick(); cyc++; end
    if (!mdi.out_valid) chk("valid_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic handshake();
    mdi.out_ready = 1;
    tick();
    mdi.out_ready = 0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ce, input int hold, output int lat);
    issue(op, a, b, ce);
    wait_valid(lat);
    repeat (hold) tick();
    handshake();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int lat, exp_early;

  initial begin
    reset = 0; flush = 0;
    mdi.in_valid = 0; mdi.in_op = 0; mdi.in_src1 = 0; mdi.in_src2 = 0;
    mdi.out_ready = 0; mdi.commit_en = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_in_ready", mdi.in_ready, 1'b1);
    chk("rst_out_valid", mdi.out_valid, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    tick();

    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1, 0, lat);
    chk("mult_lat", 32'(lat), 32'd2);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_valid(lat);
    chk("divmin_lat", 32'(lat), 32'd33);
    repeat (5) tick();
    chk("hold_hi", hi, 32'hFFFFFFFF);
    chk("hold_out_lo", mdi.out_lo, 32'h80000000);
    handshake();
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'h0);

    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 1, 1, lat);
    chk("div7_lat", 32'(lat), 32'd33);
    chk("div7_lo", lo, 32'hFFFFFFFD);
    chk("div7_hi", hi, 32'h1);

    run_op(3'd4, 32'd5, 32'd0, 1, 0, lat);
    chk("div0_lat", 32'(lat), 32'd33);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'h5);

`ifdef MD_DIV_EARLY_OUT_EN
    exp_early = 2;
`else
    exp_early = 33;
`endif
    run_op(3'd4, 32'd3, 32'd10, 1, 0, lat);
    chk("divu_small_lat", 32'(lat), 32'(exp_early));
    chk("divu_small_lo", lo, 32'h0);
    chk("divu_small_hi", hi, 32'h3);

    run_op(3'd5, 32'h12345678, 32'h0, 1, 0, lat);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'h0);
    run_op(3'd6, 32'h9ABCDEF0, 32'h0, 1, 2, lat);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);

    run_op(3'd1, 32'd7, 32'd7, 0, 0, lat);
    chk("nocommit_hi", hi, 32'h12345678);
    chk("nocommit_lo", lo, 32'h9ABCDEF0);

    run_op(3'd0, 32'd1, 32'd1, 1, 0, lat);
    chk("nop_lat", 32'(lat), 32'd1);
    chk("nop_hi", hi, 32'h12345678);

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, lat);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(3'd3, 32'd100, 32'd7, 1);
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_hi", hi, 32'hFFFFFFFE);
    chk("flush_lo", lo, 32'h1);

    issue(3'd1, 32'd3, 32'd3, 1);
    wait_valid(lat);
    flush = 1; mdi.out_ready = 1;
    tick();
    flush = 0; mdi.out_ready = 0;
    chk("flush_hs_valid", mdi.out_valid, 1'b0);
    chk("flush_hs_lo", lo, 32'h1);

    issue(3'd4, 32'd1000, 32'd3, 1);
    repeat (6) tick();
    #2 reset = 0;
    #1;
    chk("amid_valid", mdi.out_valid, 1'b0);
    chk("amid_hi", hi, 32'h0);
    chk("amid_lo", lo, 32'h0);
    tick();
    #2 reset = 1;
    #1;
    chk("amid_ready", mdi.in_ready, 1'b1);
    tick();

    for (int i = 0; i < 250; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 9) == 0) begin
        issue(op, a, b, 1);
        repeat ($urandom_range(0, 40)) tick();
        flush = 1;
        tick();
        flush = 0;
      end else begin
        run_op(op, a, b, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), lat);
      end
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the execute stage.
- Replaces the inline mul/div/HI-LO logic; the execute stage issues ops and stalls on in_ready/out_valid.
- Adds valid/ready on both sides, configurable multiplier pipeline depth, defined divide corner cases, and commit gating so excepting instructions never update HI/LO.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- MUL_STAGES, 2, multiplier latency in cycles, legal range 1..4.
- CNT_W, 6, iteration counter width, must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- flush  in  1  pipeline flush (exception/eret); cancels any op in flight.
- in_valid  in  1  op request.
- in_ready  out  1  unit can accept an op.
- in_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- in_src1  in  WIDTH  rs value (dividend / multiplicand / MT source).
- in_src2  in  WIDTH  rt value (divisor / multiplier).
- out_valid  out  1  result ready for commit.
- out_ready  in  1  downstream (memory stage) allowin.
- commit_en  in  1  sampled at the out handshake; 0 blocks the HI/LO write (exception in a younger stage).
- out_hi  out  WIDTH  result high half / remainder.
- out_lo  out  WIDTH  result low half / quotient.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; hi, lo, out_hi, out_lo = 0; out_valid = 0; in_ready = 1.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready.
- FSM states and transitions:
  - IDLE: on accept go to MUL, DIV, or DONE (MTHI/MTLO/NOP). NOP completes with out_valid but writes nothing.
  - MUL: latency MUL_STAGES cycles from accept to out_valid. Product is full 2*WIDTH; signed for MULT, unsigned for MULTU. {out_hi,out_lo} = product.
  - DIV: restoring radix-2, one quotient bit per cycle, WIDTH iterations. out_valid rises WIDTH+1 cycles after accept. Signed ops operate on magnitudes; quotient sign = s1^s2; remainder sign = sign of dividend.
  - DONE: out_valid=1 and outputs held stable until out_ready. On out_valid && out_ready: return to IDLE. If commit_en, write HI/LO on that edge (MULT/DIV both; MTHI hi only; MTLO lo only). A new op may be accepted the cycle after the handshake, not the same cycle.
- Corner cases:
  - Divide by zero: quotient all-ones, remainder = dividend; 33 cycles, no exception.
  - Signed MIN/-1: quotient = MIN, remainder = 0.
- flush from any state: next state IDLE, out_valid=0, no HI/LO write even if out_ready is also high. Flush beats accept and handshake in the same cycle.
- hi/lo read ports reflect committed values only; there is no bypass of in-flight results.
- Operands are latched at accept; input changes afterwards are ignored.

Optional Feature:
- Macro MD_DIV_EARLY_OUT_EN.
- Defined: a divide with |dividend| < |divisor| (divisor nonzero) goes directly to DONE with quotient 0 and remainder = dividend, with out_valid 2 cycles after accept.
- Undefined: every divide takes WIDTH+1 cycles.

Decomposition:
- Package md_pkg holds the op encodings (MD_NOP..MD_MTLO), state encodings (S_IDLE, S_MUL, S_DIV, S_DONE), and the MUL_STAGES range check.
- One sub-module, md_divider: iterative core with start, done, signed, dividend, divisor, quotient, remainder, and abort tied to flush.
- Multiplier is a pipelined shift register of MUL_STAGES product registers inside the top.

Test Plan:
- Reset low mid-DIV: out_valid=0, hi=lo=0 immediately (async); after release in_ready=1.
- MULT -3 x 5 (WIDTH=32, MUL_STAGES=2), out_ready=1, commit_en=1: out_valid on cycle 2; hi=FFFFFFFF, lo=FFFFFFF1.
- DIV 7 / -2: out_valid at cycle 33; lo=FFFFFFFD (-3), hi=00000001. DIVU 5/0: lo=FFFFFFFF, hi=5.
- DIV 80000000 / FFFFFFFF: lo=80000000, hi=0. out_ready held low 5 cycles: outputs stable; HI/LO unchanged until handshake.
- flush asserted at DIV cycle 10: busy=0 next cycle; HI/LO retain prior values. MULT with commit_en=0 at handshake: HI/LO unchanged.
- MD_DIV_EARLY_OUT_EN: DIVU 3/10 gives out_valid at cycle 2, lo=0, hi=3. Without the macro the same op takes 33 cycles.
